// File: rtl/md_unit.sv
// Shared iterative multiply/divide engine: radix-2 shift-add multiply and restoring divide.
// Build option MD_DIVZERO_FAST_EN: divide by zero bypasses the iteration phase.
module md_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             annul,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

`ifdef MD_DIVZERO_FAST_EN
   localparam bit DIVZ_FAST = 1'b1;
`else
   localparam bit DIVZ_FAST = 1'b0;
`endif

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               neg_res;
   logic               a_neg;
   logic               divz;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;

   logic               in_signed;
   logic               in_a_neg;
   logic               in_b_neg;
   logic               in_divz;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] prod_neg;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   assign busy = (state == CALC) || (state == FIX);
   assign done = (state == DONE);

   assign in_signed = ~op[0];
   assign in_a_neg  = in_signed & src_a[WIDTH-1];
   assign in_b_neg  = in_signed & src_b[WIDTH-1];
   assign in_divz   = op[1] && (src_b == '0);

   // One iteration: multiply adds the multiplicand into the upper half and shifts right;
   // divide shifts the next dividend bit into the partial remainder and trial-subtracts.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
      div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_trial - {1'b0, b_mag};
      acc_step  = {mul_sum, acc[WIDTH-1:1]};
      if (op_r[1]) begin
         if (!div_diff[WIDTH])
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

   // Sign correction; the most-negative / -1 case falls out as the natural wrap.
   always_comb begin
      prod_neg = -acc;
      fix_hi   = acc[2*WIDTH-1:WIDTH];
      fix_lo   = acc[WIDTH-1:0];
      if (!op_r[1]) begin
         if (neg_res)
            {fix_hi, fix_lo} = prod_neg;
      end else if (divz) begin
         fix_lo = '1;
         fix_hi = a_neg ? -a_mag : a_mag;
      end else begin
         if (neg_res)
            fix_lo = -acc[WIDTH-1:0];
         if (a_neg)
            fix_hi = -acc[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         op_r    <= '0;
         a_mag   <= '0;
         b_mag   <= '0;
         neg_res <= 1'b0;
         a_neg   <= 1'b0;
         divz    <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         hi      <= '0;
         lo      <= '0;
      end else if (annul) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  op_r    <= op;
                  a_mag   <= in_a_neg ? -src_a : src_a;
                  b_mag   <= in_b_neg ? -src_b : src_b;
                  neg_res <= in_a_neg ^ in_b_neg;
                  a_neg   <= in_a_neg;
                  divz    <= in_divz;
                  cnt     <= '0;
                  acc     <= {{WIDTH{1'b0}}, (in_a_neg ? -src_a : src_a)};
                  state   <= (DIVZ_FAST && in_divz) ? FIX : CALC;
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               acc <= acc_step;
               cnt <= cnt + 1'b1;
               if (cnt == LAST_CNT)
                  state <= FIX;
            end
            FIX: begin
               hi    <= fix_hi;
               lo    <= fix_lo;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised iterative multiply/divide unit for the execute stage. Replaces the separate multiplier and divider instances with one shared engine. Adds a width parameter, a single start/done handshake, annul (flush) support, and defined divide-by-zero results. The execute stage drives it, stalls while `busy` is high, and forwards `{hi, lo}` onto the HI/LO write bus.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Must be even and at least 4.
- `CNT_W`, default 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a new operation; sampled only when `busy`=0.
- `op`  in  2  operation select: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- `src_a`  in  WIDTH  multiplicand / dividend (rs).
- `src_b`  in  WIDTH  multiplier / divisor (rt).
- `annul`  in  1  abort the current operation (pipeline flush).
- `busy`  out  1  operation in flight; the execute stage raises its stall request from this.
- `done`  out  1  single-cycle pulse; `hi`/`lo` are valid from this cycle on.
- `hi`  out  WIDTH  product high half, or remainder.
- `lo`  out  WIDTH  product low half, or quotient.

## Operation
- State machine has four states: IDLE, CALC, FIX, DONE.
- **Accept.** In IDLE or DONE, `start`=1 with `annul`=0 is accepted.
  - Latches `op`.
  - Latches the operand magnitudes |src_a| and |src_b|, taken as absolute values for signed ops and raw for unsigned ops.
  - Latches sign flags and clears the counter.
  - Next state is CALC.
- **CALC, multiply.** Radix-2 shift-add on a 2·WIDTH accumulator, one multiplier bit per cycle, WIDTH cycles.
- **CALC, divide.** Restoring division, one quotient bit per cycle, WIDTH cycles.
- **FIX.** One cycle.
  - Product is negated if the operand signs differ (signed mult only).
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend (signed div only).
  - Result is written into the `hi`/`lo` registers.
  - Next state is DONE.
- **DONE.** `done`=1 for one cycle. Returns to IDLE, or to CALC if a new start is accepted in the same cycle.
- **Divide by zero** (`src_b`=0, div or divu): `lo`=all ones, `hi`=`src_a` (raw), regardless of sign.
- **Signed overflow** (most-negative / -1): `lo`=most-negative, `hi`=0. This is the two's-complement wrap.
- `hi`/`lo` hold their value until the next FIX writes them. They are unaffected by annul.
- `start` while `busy`=1 is ignored. No queueing.
- **Annul.** `annul`=1 in any state forces IDLE on the next edge: no `done`, `hi`/`lo` retained. In IDLE/DONE, `annul` has priority over a simultaneous `start`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0. Reset takes effect immediately on `rst` rising, including mid-operation.
- `busy` is combinational from the state: 1 in CALC and FIX, 0 in IDLE and DONE.
- Latency: start accepted at edge N puts the unit in CALC for edges N+1..N+WIDTH, FIX at N+WIDTH+1, and `done`=1 in cycle N+WIDTH+2 (34 for WIDTH=32).
- Back-to-back operations: a start accepted during the DONE cycle gives a throughput of WIDTH+2 cycles per op.
- Operand bus values are needed only in the accept cycle. The execute stage may change them afterwards.

## Configuration
- `MD_DIVZERO_FAST_EN`
  - **Defined:** divide by zero skips CALC. Accept → FIX → DONE, so `done` arrives 2 cycles after accept.
  - **Undefined:** divide by zero runs the full WIDTH+2 latency.
  - The `hi`/`lo` values are identical in both builds.

## Test plan
- **Unsigned multiply:** multu 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` 34 cycles after accept; `busy` high for cycles 1–33.
- **Signed multiply and divide:**
  - mult -3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
  - div -7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- **Corner cases:**
  - div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - divu 7 / 0 → `lo`=0xFFFFFFFF, `hi`=7; `done` at cycle 2 with the macro defined, cycle 34 without.
- **Annul and restart:** annul at cycle 10 of a divu → `busy`=0 next cycle, no `done`, `hi`/`lo` keep the prior result. A start in that same IDLE cycle is accepted and completes normally.
- **Ignored start and back-to-back:** start pulsed during CALC → ignored (single `done`). Start during the DONE cycle → second `done` exactly 34 cycles later.
- **Async reset:** `rst` asserted mid-CALC asynchronously (between edges) → `busy`/`done`/`hi`/`lo` go to 0 before the next edge. After release, a mult 6 × 7 gives `lo`=42.
